// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device command transmitter: inhibit, start, 8 data bits, odd parity, stop, ACK.
// Optional retry (up to 3 attempts on NAK or timeout) when PS2_HOST_TX_RETRY_EN is defined.
module ps2_host_tx #(
   parameter int INHIBIT_CYCLES = 5000,
   parameter int TIMEOUT_CYCLES = 750000,
   parameter int SYNC_STAGES    = 2
) (
   input  logic       clock,
   input  logic       reset_n,
   input  logic [7:0] tx_data,
   input  logic       tx_valid,
   output logic       tx_ready,
   input  logic       ps2_clk_in,
   input  logic       ps2_data_in,
   output logic       ps2_clk_oe,
   output logic       ps2_data_oe,
   output logic       busy,
   output logic       done,
   output logic       error
);

   localparam int IW = $clog2(INHIBIT_CYCLES + 1);
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [IW-1:0] INH_LAST = IW'(INHIBIT_CYCLES - 1);
   localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT_CYCLES - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_INHIBIT,
      S_RELEASE,
      S_SEND,
      S_ACK_WAIT,
      S_RELEASE_WAIT,
      S_DONE
   } state_t;

   state_t                 state;
   logic [SYNC_STAGES-1:0] clk_sync;
   logic [SYNC_STAGES-1:0] data_sync;
   logic                   clk_prev;
   logic [7:0]             data_reg;
   logic [IW-1:0]          inh_cnt;
   logic [TW-1:0]          to_cnt;
   logic [3:0]             bit_cnt;
   logic                   nak;

   logic clk_s, data_s, fall, accept, in_frame;
   logic timeout_hit, release_ok, finish, fail_now, retry;

   assign clk_s       = clk_sync[SYNC_STAGES-1];
   assign data_s      = data_sync[SYNC_STAGES-1];
   assign fall        = clk_prev & ~clk_s;
   assign accept      = tx_valid & tx_ready;
   assign in_frame    = (state == S_SEND) || (state == S_ACK_WAIT) || (state == S_RELEASE_WAIT);
   assign timeout_hit = in_frame && !fall && (to_cnt == TO_LAST);
   assign release_ok  = (state == S_RELEASE_WAIT) && clk_s && data_s;
   assign finish      = timeout_hit || release_ok;
   assign fail_now    = timeout_hit || (release_ok && nak);

`ifdef PS2_HOST_TX_RETRY_EN
   logic [1:0] retry_cnt;

   // Two retries after the first failed attempt; the count restarts with every new byte.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n)
         retry_cnt <= 2'd0;
      else if (accept)
         retry_cnt <= 2'd0;
      else if (fail_now && retry_cnt != 2'd2)
         retry_cnt <= retry_cnt + 2'd1;
   end

   assign retry = fail_now && (retry_cnt != 2'd2);
`else
   assign retry = 1'b0;
`endif

   // The pad levels are asynchronous, so both pass through a reset-to-idle synchronizer.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         clk_sync  <= '1;
         data_sync <= '1;
         clk_prev  <= 1'b1;
      end else begin
         clk_sync  <= {clk_sync[SYNC_STAGES-2:0], ps2_clk_in};
         data_sync <= {data_sync[SYNC_STAGES-2:0], ps2_data_in};
         clk_prev  <= clk_s;
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state       <= S_IDLE;
         tx_ready    <= 1'b1;
         busy        <= 1'b0;
         done        <= 1'b0;
         error       <= 1'b0;
         ps2_clk_oe  <= 1'b0;
         ps2_data_oe <= 1'b0;
         data_reg    <= 8'h00;
         inh_cnt     <= '0;
         to_cnt      <= '0;
         bit_cnt     <= 4'd0;
         nak         <= 1'b0;
      end else if (finish) begin
         // Both lines are released on every exit; a retry re-inhibits with the same byte.
         to_cnt      <= '0;
         ps2_data_oe <= 1'b0;
         if (retry) begin
            state      <= S_INHIBIT;
            ps2_clk_oe <= 1'b1;
            inh_cnt    <= '0;
            nak        <= 1'b0;
         end else begin
            state      <= S_DONE;
            ps2_clk_oe <= 1'b0;
            done       <= 1'b1;
            error      <= fail_now;
         end
      end else begin
         case (state)
            S_IDLE: begin
               if (accept) begin
                  data_reg   <= tx_data;
                  state      <= S_INHIBIT;
                  ps2_clk_oe <= 1'b1;
                  busy       <= 1'b1;
                  tx_ready   <= 1'b0;
                  inh_cnt    <= '0;
                  nak        <= 1'b0;
               end
            end
            S_INHIBIT: begin
               if (inh_cnt == INH_LAST) begin
                  ps2_data_oe <= 1'b1;
                  state       <= S_RELEASE;
               end else begin
                  inh_cnt <= inh_cnt + 1'b1;
               end
            end
            S_RELEASE: begin
               ps2_clk_oe <= 1'b0;
               state      <= S_SEND;
               bit_cnt    <= 4'd0;
               to_cnt     <= '0;
            end
            S_SEND: begin
               // bit_cnt holds the number of falls already seen in this frame.
               if (fall) begin
                  to_cnt  <= '0;
                  bit_cnt <= bit_cnt + 4'd1;
                  if (bit_cnt < 4'd8)
                     ps2_data_oe <= ~data_reg[bit_cnt[2:0]];
                  else if (bit_cnt == 4'd8)
                     ps2_data_oe <= ^data_reg;
                  else begin
                     ps2_data_oe <= 1'b0;
                     state       <= S_ACK_WAIT;
                  end
               end else begin
                  to_cnt <= to_cnt + 1'b1;
               end
            end
            S_ACK_WAIT: begin
               if (fall) begin
                  to_cnt <= '0;
                  nak    <= data_s;
                  state  <= S_RELEASE_WAIT;
               end else begin
                  to_cnt <= to_cnt + 1'b1;
               end
            end
            S_RELEASE_WAIT: begin
               if (fall)
                  to_cnt <= '0;
               else
                  to_cnt <= to_cnt + 1'b1;
            end
            S_DONE: begin
               done     <= 1'b0;
               error    <= 1'b0;
               tx_ready <= 1'b1;
               busy     <= 1'b0;
               state    <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule
